// File: rtl/gemm_mmio_ctrl_if.sv
// Core data-memory port as seen by the GEMM MMIO block.
// master = core side (drives the access), slave = gemm_mmio_ctrl.
interface gemm_mmio_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] rdata;
    logic        hit;
    logic        wait_for_gemm;

    modport master (
        output addr, wdata, mem_write, mem_read,
        input  rdata, hit, wait_for_gemm
    );

    modport slave (
        input  addr, wdata, mem_write, mem_read,
        output rdata, hit, wait_for_gemm
    );
endinterface

// File: rtl/gemm_mmio_ctrl.sv
// GEMM configuration registers, launch FSM and busy-cycle counter, mapped into
// a 256 B region of the core data space. Raises wait_for_gemm on busy accesses.
module gemm_mmio_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000
) (
    input  logic              clk,
    input  logic              rst_n,
    gemm_mmio_ctrl_if.slave   bus,
    output logic              gemm_start,
    output logic [31:0]       gemm_a_base,
    output logic [31:0]       gemm_b_base,
    output logic [31:0]       gemm_c_base,
    output logic [7:0]        gemm_m,
    output logic [7:0]        gemm_n,
    output logic [7:0]        gemm_k,
    input  logic              gemm_done,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } state_t;

    state_t      state;
    logic        done;
    logic        err;
    logic [31:0] cycles;

    logic [7:0]  offset;
    logic        busy;
    logic        wr_en;
    logic        ctrl_wr;
    logic        dims_ok;
    logic        unused_addr_bits;

    assign offset           = bus.addr[7:0];
    assign unused_addr_bits = ^bus.addr[1:0];
    assign busy             = (state != IDLE);
    assign fsm_state        = state;

    // Handshake: a region access (hit) is accepted in a cycle where
    // wait_for_gemm is low; while it is high the core holds addr/wdata/strobes
    // unchanged and nothing is committed. Only STATUS reads bypass the stall.
    assign bus.hit           = (bus.addr[31:8] == BASE_ADDR[31:8]) && (bus.mem_read || bus.mem_write);
    assign bus.wait_for_gemm = bus.hit && busy && !(bus.mem_read && offset == 8'h04);

    assign wr_en   = bus.hit && bus.mem_write && !bus.wait_for_gemm;
    assign ctrl_wr = wr_en && (offset == 8'h00) && (state == IDLE);
    assign dims_ok = (gemm_m != 8'd0) && (gemm_n != 8'd0) && (gemm_k != 8'd0);

    always_comb begin
        bus.rdata = 32'd0;
        if (bus.hit) begin
            case (offset)
                8'h04:   bus.rdata = {29'd0, err, done, busy};
                8'h08:   bus.rdata = gemm_a_base;
                8'h0C:   bus.rdata = gemm_b_base;
                8'h10:   bus.rdata = gemm_c_base;
                8'h14:   bus.rdata = {8'd0, gemm_k, gemm_n, gemm_m};
                8'h18:   bus.rdata = cycles;
                default: bus.rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            gemm_start  <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cycles      <= 32'd0;
            gemm_a_base <= 32'd0;
            gemm_b_base <= 32'd0;
            gemm_c_base <= 32'd0;
            gemm_m      <= 8'd0;
            gemm_n      <= 8'd0;
            gemm_k      <= 8'd0;
        end else begin
            gemm_start <= 1'b0;

            if (wr_en) begin
                case (offset)
                    8'h08:   gemm_a_base <= bus.wdata;
                    8'h0C:   gemm_b_base <= bus.wdata;
                    8'h10:   gemm_c_base <= bus.wdata;
                    8'h14:   {gemm_k, gemm_n, gemm_m} <= bus.wdata[23:0];
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    // Start takes priority over clr_done when both bits are set.
                    if (ctrl_wr && bus.wdata[0]) begin
                        if (dims_ok) begin
                            state      <= LAUNCH;
                            gemm_start <= 1'b1;
                            done       <= 1'b0;
                            err        <= 1'b0;
                            cycles     <= 32'd0;
                        end else begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end else if (ctrl_wr && bus.wdata[1]) begin
                        done <= 1'b0;
                        err  <= 1'b0;
                    end
                end
                LAUNCH: begin
                    state <= BUSY;
                    if (cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
                end
                BUSY: begin
                    if (cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
                    if (gemm_done) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_mmio_ctrl.sv
// Directed bench for gemm_mmio_ctrl: configuration, launch, stalls, done,
// zero-dimension error and reset while busy.
module tb_gemm_mmio_ctrl;

    localparam logic [31:0] BASE = 32'h0000_4000;

    logic        clk;
    logic        rst_n;
    logic        gemm_done;
    logic        gemm_start;
    logic [31:0] gemm_a_base, gemm_b_base, gemm_c_base;
    logic [7:0]  gemm_m, gemm_n, gemm_k;
    logic [1:0]  fsm_state;

    int unsigned n_cmp;
    int unsigned n_err;
    logic [31:0] exp_q[$];

    gemm_mmio_ctrl_if bus ();

    gemm_mmio_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .gemm_start  (gemm_start),
        .gemm_a_base (gemm_a_base),
        .gemm_b_base (gemm_b_base),
        .gemm_c_base (gemm_c_base),
        .gemm_m      (gemm_m),
        .gemm_n      (gemm_n),
        .gemm_k      (gemm_k),
        .gemm_done   (gemm_done),
        .fsm_state   (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive everything at the falling edge, settle, return.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic dn);
        @(negedge clk);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.addr      = a;
        bus.wdata     = d;
        gemm_done     = dn;
        #1;
    endtask

    task automatic idle_cycle();
        access(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic wr_reg(input logic [7:0] off, input logic [31:0] d);
        access(1'b0, 1'b1, BASE + {24'd0, off}, d, 1'b0);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] off, input logic [31:0] exp);
        access(1'b1, 1'b0, BASE + {24'd0, off}, 32'd0, 1'b0);
        check(tag, bus.rdata, exp);
    endtask

    logic [7:0]  cfg_off[4];
    logic [31:0] cfg_val[4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        cfg_off = '{8'h08, 8'h0C, 8'h10, 8'h14};
        cfg_val = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0004_0404};

        rst_n         = 1'b0;
        gemm_done     = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr      = 32'd0;
        bus.wdata     = 32'd0;

        repeat (2) idle_cycle();
        rst_n = 1'b1;
        idle_cycle();
        check("rst_state", {30'd0, fsm_state}, 32'd0);
        check("rst_start", {31'd0, gemm_start}, 32'd0);
        check("rst_wait", {31'd0, bus.wait_for_gemm}, 32'd0);
        check("rst_rdata_nohit", bus.rdata, 32'd0);
        rd_check("rst_status", 8'h04, 32'd0);
        rd_check("rst_cycles", 8'h18, 32'd0);

        // configure and read back
        for (int i = 0; i < 4; i++) begin
            wr_reg(cfg_off[i], cfg_val[i]);
            exp_q.push_back(cfg_val[i]);
        end
        for (int i = 0; i < 4; i++) rd_check("cfg_readback", cfg_off[i], exp_q.pop_front());
        rd_check("dims_upper_zero", 8'h14, 32'h0004_0404);
        check("port_a", gemm_a_base, 32'h0000_0100);
        check("port_b", gemm_b_base, 32'h0000_0200);
        check("port_c", gemm_c_base, 32'h0000_0300);
        check("port_dims", {8'd0, gemm_k, gemm_n, gemm_m}, 32'h0004_0404);
        rd_check("ctrl_reads_zero", 8'h00, 32'd0);
        rd_check("unmapped_reads_zero", 8'h1C, 32'd0);

        // C0: start write; C1: LAUNCH
        wr_reg(8'h00, 32'd1);
        check("no_start_before_edge", {31'd0, gemm_start}, 32'd0);
        access(1'b1, 1'b0, BASE + 32'h04, 32'd0, 1'b0);
        check("start_pulse", {31'd0, gemm_start}, 32'd1);
        check("state_launch", {30'd0, fsm_state}, 32'd1);
        check("status_launch", bus.rdata, 32'h1);
        check("status_no_wait_launch", {31'd0, bus.wait_for_gemm}, 32'd0);
        // C2
        access(1'b1, 1'b0, BASE + 32'h04, 32'd0, 1'b0);
        check("start_one_cycle", {31'd0, gemm_start}, 32'd0);
        check("status_busy", bus.rdata, 32'h1);
        check("status_no_wait_busy", {31'd0, bus.wait_for_gemm}, 32'd0);
        // C3: DIMS write stalls
        access(1'b0, 1'b1, BASE + 32'h14, 32'h0005_0505, 1'b0);
        check("dims_wr_wait", {31'd0, bus.wait_for_gemm}, 32'd1);
        check("dims_wr_hit", {31'd0, bus.hit}, 32'd1);
        // C4: A_BASE read stalls
        access(1'b1, 1'b0, BASE + 32'h08, 32'd0, 1'b0);
        check("a_rd_wait", {31'd0, bus.wait_for_gemm}, 32'd1);
        // C5: outside the region
        access(1'b1, 1'b0, 32'h0000_5000, 32'd0, 1'b0);
        check("outside_hit", {31'd0, bus.hit}, 32'd0);
        check("outside_wait", {31'd0, bus.wait_for_gemm}, 32'd0);
        check("outside_rdata", bus.rdata, 32'd0);
        // C6..C10
        repeat (5) idle_cycle();
        check("dims_unchanged_busy", {24'd0, gemm_m}, 32'd4);
        // C11: done cycle with a held DIMS write
        access(1'b0, 1'b1, BASE + 32'h14, 32'h0005_0505, 1'b1);
        check("held_wr_wait_done_cycle", {31'd0, bus.wait_for_gemm}, 32'd1);
        check("state_busy", {30'd0, fsm_state}, 32'd2);
        // C12: back in IDLE, held write now commits
        access(1'b0, 1'b1, BASE + 32'h14, 32'h0005_0505, 1'b0);
        check("held_wr_no_wait", {31'd0, bus.wait_for_gemm}, 32'd0);
        check("state_idle_after_done", {30'd0, fsm_state}, 32'd0);
        check("dims_not_yet", {24'd0, gemm_m}, 32'd4);
        rd_check("status_done", 8'h04, 32'h2);
        check("dims_committed", {8'd0, gemm_k, gemm_n, gemm_m}, 32'h0005_0505);
        rd_check("cycles_count", 8'h18, 32'd11);
        wr_reg(8'h00, 32'd2);
        rd_check("status_cleared", 8'h04, 32'h0);
        rd_check("cycles_hold_idle", 8'h18, 32'd11);

        // zero dimension
        wr_reg(8'h14, 32'h0000_0404);
        wr_reg(8'h00, 32'd1);
        idle_cycle();
        check("zero_dim_no_start", {31'd0, gemm_start}, 32'd0);
        check("zero_dim_state", {30'd0, fsm_state}, 32'd0);
        rd_check("zero_dim_status", 8'h04, 32'h6);
        wr_reg(8'h00, 32'd2);
        rd_check("zero_dim_clr", 8'h04, 32'h0);
        wr_reg(8'h00, 32'd3);
        rd_check("start_wins_over_clr", 8'h04, 32'h6);

        // reset while busy
        wr_reg(8'h14, 32'h0001_0203);
        wr_reg(8'h00, 32'd1);
        idle_cycle();
        idle_cycle();
        check("busy_before_reset", {30'd0, fsm_state}, 32'd2);
        rst_n = 1'b0;
        idle_cycle();
        rst_n = 1'b1;
        rd_check("rst_busy_status", 8'h04, 32'h0);
        rd_check("rst_busy_a", 8'h08, 32'h0);
        rd_check("rst_busy_dims", 8'h14, 32'h0);
        rd_check("rst_busy_cycles", 8'h18, 32'h0);
        check("rst_busy_port_a", gemm_a_base, 32'd0);
        access(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        idle_cycle();
        rd_check("late_done_ignored", 8'h04, 32'h0);
        check("late_done_state", {30'd0, fsm_state}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
